// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 8N1 UART transmitter and receiver.
// Holds the default clocks-per-bit, the data width, the idle line level
// and the receiver state encoding.
package uart_pkg;

    localparam int unsigned CPB_DEFAULT = 1250;  // 12 MHz / 9600 baud
    localparam int unsigned DATA_BITS   = 8;
    localparam logic        IDLE_LEVEL  = 1'b1;  // serial line idles high

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input pin.
// Ports:
//   clk_i  - system clock
//   rst_ni - synchronous active-low reset; both flops load RESET_VAL
//   d_i    - asynchronous input
//   q_o    - synchronized output (two clocks of latency)
module uart_sync2
    import uart_pkg::*;
#(
    parameter logic RESET_VAL = IDLE_LEVEL
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8 data bits, LSB first, no parity, 1 stop bit).
// Ports:
//   clk       - system clock, all logic on its rising edge
//   rst_n     - synchronous active-low reset
//   rx        - asynchronous serial line, idle high
//   data      - last correctly framed byte
//   valid     - one-cycle pulse when data is updated
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   busy      - high from start-edge detection until return to IDLE
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CPB = CPB_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = $clog2(CPB);
    localparam int unsigned IW   = $clog2(DATA_BITS);

    typedef logic [CW-1:0] cnt_t;

    rx_state_e              state_q, state_d;
    cnt_t                   cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   rx_s;

    uart_sync2 #(.RESET_VAL(IDLE_LEVEL)) u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_s != IDLE_LEVEL) state_d = START;
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than HALF
                if (cnt_q == cnt_t'(HALF - 1)) begin
                    cnt_d = '0;
                    if (rx_s == IDLE_LEVEL) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            DATA: begin
                if (cnt_q == cnt_t'(CPB - 1)) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
                    else                             idx_d   = idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            STOP: begin
                if (cnt_q == cnt_t'(CPB - 1)) begin
                    cnt_d = '0;
                    if (rx_s == IDLE_LEVEL) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            BREAK: begin
                // Hold off start detection until the line returns high
                cnt_d = '0;
                if (rx_s == IDLE_LEVEL) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                shreg_d = '0;
                data_d  = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        data      = data_q;
        valid     = valid_q;
        frame_err = ferr_q;
        case (state_q)
            START, DATA, STOP, BREAK: busy = 1'b1;
            default:                  busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CPB = 16 with a behavioural
// receiver model compared against the DUT on every cycle.
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CPB(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int { M_IDLE, M_FRAME, M_BREAK } mmode_e;
    mmode_e      mmode = M_IDLE;
    int unsigned cyc   = 0;
    int unsigned t0    = 0;
    int unsigned m_vt0 = 0;
    logic        p1 = 1'b1, p2 = 1'b1;
    logic [7:0]  mbyte = '0;
    logic [7:0]  m_data = '0;
    logic        m_valid = 1'b0, m_ferr = 1'b0;

    task automatic model_step();
        logic rs;
        int unsigned k, bi;
        cyc++;
        rs      = p2;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        if (!rst_n) begin
            p1 = 1'b1; p2 = 1'b1;
            mmode  = M_IDLE;
            m_data = '0;
        end else begin
            p2 = p1;
            p1 = rx;
            case (mmode)
                M_IDLE: if (!rs) begin mmode = M_FRAME; t0 = cyc; end
                M_FRAME: begin
                    k = cyc - t0;
                    if (k == HALF) begin
                        if (rs) mmode = M_IDLE;
                    end else if (k > HALF && (k - HALF) % CPB == 0) begin
                        bi = (k - HALF) / CPB;
                        if (bi <= 8) begin
                            mbyte[bi-1] = rs;
                        end else if (rs) begin
                            m_data  = mbyte;
                            m_valid = 1'b1;
                            m_vt0   = t0;
                            mmode   = M_IDLE;
                        end else begin
                            m_ferr = 1'b1;
                            mmode  = M_BREAK;
                        end
                    end
                end
                M_BREAK: if (rs) mmode = M_IDLE;
                default: mmode = M_IDLE;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare / monitor ----------------
    logic        checking = 1'b0;
    int unsigned n_valid = 0, n_ferr = 0, last_valid_cyc = 0;
    logic [7:0]  last_byte = '0, prev_byte = '0;
    logic        busy_at_valid = 1'b0;

    initial forever begin
        @(negedge clk);
        if (checking) begin
            chk("valid",     valid,     m_valid);
            chk("frame_err", frame_err, m_ferr);
            chk("busy",      busy,      (mmode != M_IDLE));
            chk("data",      data,      m_data);
            if (valid) begin
                n_valid++;
                prev_byte      = last_byte;
                last_byte      = data;
                last_valid_cyc = cyc;
                busy_at_valid  = busy;
            end
            if (frame_err) n_ferr++;
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        rx = 1'b1;
        repeat (n) step();
    endtask

    // p100: bit period in hundredths of a clock; rst_at: frame cycle to pulse reset (0 = none)
    task automatic send_frame(input logic [7:0] b, input int unsigned p100,
                              input logic stop_bit, input int unsigned rst_at);
        logic [9:0]  fr;
        int unsigned len, n;
        fr = {stop_bit, b, 1'b0};
        n  = 0;
        for (int unsigned j = 0; j < 10; j++) begin
            rx  = fr[j];
            len = ((j + 1) * p100) / 100 - (j * p100) / 100;
            for (int unsigned s = 0; s < len; s++) begin
                n++;
                if (rst_at != 0 && n == rst_at) begin
                    rst_n = 1'b0;
                    step();
                    rst_n = 1'b1;
                    rx    = 1'b1;
                    return;
                end
                step();
            end
        end
        rx = 1'b1;
    endtask

    task automatic clr();
        n_valid = 0;
        n_ferr  = 0;
    endtask

    initial begin
        int unsigned sweep[3];
        sweep[0] = 1552; sweep[1] = 1600; sweep[2] = 1648;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) step();
        rst_n    = 1'b1;
        checking = 1'b1;
        chk("rst_data",  data,      8'h00);
        chk("rst_valid", valid,     0);
        chk("rst_ferr",  frame_err, 0);
        chk("rst_busy",  busy,      0);
        idle(10);

        // two idle-separated frames
        clr();
        send_frame(8'h55, 1600, 1'b1, 0); idle(20);
        chk("t_valid_offset", last_valid_cyc - m_vt0, HALF + 9 * CPB);
        chk("t_busy_at_valid", busy_at_valid, 0);
        send_frame(8'hA3, 1600, 1'b1, 0); idle(20);
        chk("t1_count", n_valid, 2);
        chk("t1_first", prev_byte, 8'h55);
        chk("t1_second", last_byte, 8'hA3);

        // back-to-back frames, stop bit exactly CPB
        clr();
        send_frame(8'h00, 1600, 1'b1, 0);
        send_frame(8'hFF, 1600, 1'b1, 0); idle(20);
        chk("b2b_count", n_valid, 2);
        chk("b2b_ferr", n_ferr, 0);
        chk("b2b_first", prev_byte, 8'h00);
        chk("b2b_second", last_byte, 8'hFF);

        // false start shorter than HALF
        clr();
        rx = 1'b0; repeat (4) step();
        idle(30);
        chk("fs_valid", n_valid, 0);
        chk("fs_ferr", n_ferr, 0);
        chk("fs_busy", busy, 0);

        // framing error followed by a held-low break, then a good frame
        clr();
        send_frame(8'h3C, 1600, 1'b0, 0);
        rx = 1'b0; repeat (40) step();
        idle(20);
        chk("fe_count", n_ferr, 1);
        chk("fe_valid", n_valid, 0);
        chk("fe_data_kept", data, 8'hFF);
        send_frame(8'h81, 1600, 1'b1, 0); idle(20);
        chk("fe_recover_count", n_valid, 1);
        chk("fe_recover_data", last_byte, 8'h81);
        chk("fe_ferr_total", n_ferr, 1);

        // reset during data bit 4
        clr();
        send_frame(8'hE7, 1600, 1'b1, 5 * CPB + 8);
        chk("mr_data", data, 8'h00);
        chk("mr_valid", valid, 0);
        chk("mr_ferr", frame_err, 0);
        chk("mr_busy", busy, 0);
        idle(30);
        chk("mr_no_pulse", n_valid + n_ferr, 0);
        send_frame(8'h5A, 1600, 1'b1, 0); idle(20);
        chk("mr_next_count", n_valid, 1);
        chk("mr_next_data", last_byte, 8'h5A);

        // baud mismatch sweep
        foreach (sweep[i]) begin
            clr();
            send_frame(8'hC9, sweep[i], 1'b1, 0); idle(30);
            chk("sweep_count", n_valid, 1);
            chk("sweep_data", last_byte, 8'hC9);
            chk("sweep_ferr", n_ferr, 0);
        end

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
